// File: rtl/btn_debouncer_multi.sv
// Multi-channel button debouncer: shared sample prescaler, per-channel synchroniser,
// N-sample filter, press/release pulses and hold-to-auto-repeat.

module btn_debouncer_lane #(
  parameter int N              = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_SAMPLES   = 64,
  parameter int REPEAT_SAMPLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en_i,
  input  logic raw_i,
  input  logic en_repeat_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);
  localparam int FW   = $clog2((N > 2) ? N : 2);
  localparam int HMAX = (HOLD_SAMPLES > REPEAT_SAMPLES) ? HOLD_SAMPLES : REPEAT_SAMPLES;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [FW-1:0] FLAST  = FW'(N - 1);
  localparam logic [HW-1:0] HOLD_T = HW'(HOLD_SAMPLES);
  localparam logic [HW-1:0] REP_T  = HW'(REPEAT_SAMPLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [HW-1:0]          hcnt_q, hcnt_d, hinc;
  logic                   state_q, state_d;
  logic                   armed_q, armed_d;
  logic                   press_q, press_d, release_q, release_d, repeat_q, repeat_d;
  logic                   s;

  assign s    = sync_q[SYNC_STAGES-1];
  assign hinc = hcnt_q + 1'b1;

  always_comb begin
    fcnt_d    = fcnt_q;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sample_en_i) begin
      if (s != state_q) begin
        if (fcnt_q == FLAST) begin
          state_d   = s;
          fcnt_d    = '0;
          press_d   = s;
          release_d = ~s;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end else begin
        fcnt_d = '0;
      end
    end
  end

  // armed_q selects the repeat interval once the initial hold period has elapsed
  always_comb begin
    hcnt_d   = hcnt_q;
    armed_d  = armed_q;
    repeat_d = 1'b0;
    if (!state_q || !en_repeat_i) begin
      hcnt_d  = '0;
      armed_d = 1'b0;
    end else if (sample_en_i) begin
      if (hinc == (armed_q ? REP_T : HOLD_T)) begin
        hcnt_d   = '0;
        armed_d  = 1'b1;
        repeat_d = 1'b1;
      end else begin
        hcnt_d = hinc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      fcnt_q    <= '0;
      hcnt_q    <= '0;
      state_q   <= 1'b0;
      armed_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
      fcnt_q    <= fcnt_d;
      hcnt_q    <= hcnt_d;
      state_q   <= state_d;
      armed_q   <= armed_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;
endmodule

module btn_debouncer_multi #(
  parameter int CH             = 4,
  parameter int DIV            = 8,
  parameter int N              = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_SAMPLES   = 64,
  parameter int REPEAT_SAMPLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn_raw,
  input  logic [CH-1:0] en_repeat,
  output logic [CH-1:0] btn_state,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] release_pulse,
  output logic [CH-1:0] repeat_pulse
);
  localparam int PW = $clog2((DIV > 2) ? DIV : 2);
  localparam logic [PW-1:0] PLAST = (DIV > 1) ? PW'(DIV - 1) : '0;

  logic [PW-1:0] cnt_q;
  logic          sample_en;

  // DIV<=1 degenerates to a strobe every cycle; the counter then idles at zero
  assign sample_en = (DIV <= 1) ? 1'b1 : (cnt_q == PLAST);

  always_ff @(posedge clk) begin
    if (rst || sample_en) cnt_q <= '0;
    else                  cnt_q <= cnt_q + 1'b1;
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    btn_debouncer_lane #(
      .N(N), .SYNC_STAGES(SYNC_STAGES),
      .HOLD_SAMPLES(HOLD_SAMPLES), .REPEAT_SAMPLES(REPEAT_SAMPLES)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .sample_en_i(sample_en),
      .raw_i      (btn_raw[g]),
      .en_repeat_i(en_repeat[g]),
      .state_o    (btn_state[g]),
      .press_o    (press_pulse[g]),
      .release_o  (release_pulse[g]),
      .repeat_o   (repeat_pulse[g])
    );
  end
endmodule

// File: doc/btn_debouncer_multi.md
Name: btn_debouncer_multi

Overview:
- Multi-channel successor to the single-button debouncer.
- Synchronises CH raw button inputs and debounces each one with a shared sample prescaler and per-channel N-consecutive-sample filters.
- Per channel it emits one-cycle press and release pulses, plus optional hold-to-auto-repeat pulses.
- Sits between board pins and counter/menu logic that consumes the increment-style pulses.

Parameters:
- CH, 4: number of independent button channels (>=1).
- DIV, 8: prescaler period in clk cycles; one sample strobe every DIV cycles (DIV<=1 means every cycle).
- N, 4: consecutive disagreeing samples required to flip a debounced state (>=1).
- SYNC_STAGES, 2: flip-flop synchroniser depth on btn_raw (>=2).
- HOLD_SAMPLES, 64: samples a channel must stay pressed before its first repeat pulse (>=1).
- REPEAT_SAMPLES, 16: samples between subsequent repeat pulses (>=1).

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- btn_raw  in  CH  asynchronous raw button levels, 1 = pressed
- en_repeat  in  CH  per-channel auto-repeat enable, synchronous to clk
- btn_state  out  CH  debounced level per channel
- press_pulse  out  CH  one-cycle pulse on a debounced 0->1 transition
- release_pulse  out  CH  one-cycle pulse on a debounced 1->0 transition
- repeat_pulse  out  CH  one-cycle auto-repeat pulse while a channel is held

Behaviour:
- Reset (sampled on the clk edge with rst=1):
  - prescaler count = 0; all synchroniser flops = 0.
  - All per-channel filter counters and hold counters = 0.
  - btn_state, press_pulse, release_pulse and repeat_pulse = 0.
  - Reset mid-press drops btn_state with NO release_pulse.
  - After reset, a still-pressed button needs the full N samples before press_pulse.
- Prescaler:
  - Width is clog2(max(DIV,2)).
  - sample_en = (cnt == DIV-1); cnt wraps to 0 on sample_en, otherwise increments.
  - The first sample_en occurs DIV cycles after rst deasserts.
  - The prescaler is shared by all channels.
- Synchroniser: a SYNC_STAGES flop chain per bit, clocked every cycle; s[i] is its output.
- Filter, per channel i, on sample_en:
  - If s[i] != btn_state[i]: if fcnt == N-1, set btn_state <= s[i] and fcnt <= 0; else fcnt <= fcnt+1.
  - If s[i] == btn_state[i]: fcnt <= 0. Any agreeing sample restarts the count.
  - fcnt width is clog2(max(N,2)). With no sample_en, fcnt holds.
- Pulses:
  - press_pulse[i] and release_pulse[i] are registered. Each is high for exactly the one clk cycle in which btn_state[i] first shows its new value, i.e. the cycle after the deciding sample edge.
  - Never more than one pulse per transition.
  - press and release are never both high on the same channel.
- Auto-repeat, per channel, with hold counter hcnt sized for max(HOLD_SAMPLES, REPEAT_SAMPLES):
  - hcnt clears when btn_state = 0, when en_repeat = 0, or on a press transition.
  - On each sample_en while btn_state = 1 and en_repeat = 1, hcnt increments.
  - First repeat_pulse fires when hcnt reaches HOLD_SAMPLES; hcnt then reloads so later pulses occur every REPEAT_SAMPLES samples.
  - repeat_pulse is a registered one-cycle pulse, aligned to the cycle after that sample edge.
  - Deasserting en_repeat mid-hold stops repeats immediately. Reasserting it while still held restarts the HOLD_SAMPLES wait.
  - No repeat_pulse fires in the same cycle as press_pulse.
- Latency from a raw edge to press_pulse: SYNC_STAGES cycles + time to the next strobe + (N-1)*DIV cycles + 1 cycle.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.

Test Plan:
- Bench parameters: CH=4, DIV=8, N=4, HOLD_SAMPLES=6, REPEAT_SAMPLES=3, clk period 20 ns.
- Reset/idle: hold rst 5 cycles, all btn_raw=0 for 10 samples -> every output 0 throughout; first sample_en 8 cycles after rst deasserts.
- Clean press/release on ch0, en_repeat=0: press held 6 samples, then released 6 samples -> press_pulse[0] exactly 1 cycle, then release_pulse[0] exactly 1 cycle; btn_state[0] high between them; repeat_pulse stays 0; ch1-3 silent.
- Glitch rejection on ch1: 3-sample press, 1 sample low, 3 samples high, then low -> zero pulses and btn_state[1] stays 0. Also a 1-cycle raw spike between strobes -> ignored.
- Auto-repeat on ch2, en_repeat=1, held 20 samples after debounce -> 1 press_pulse, then repeat_pulse at hold samples 6, 9, 12, 15, 18 (5 pulses), then 1 release_pulse. Dropping en_repeat at hold sample 10 -> only 2 repeats.
- Simultaneous channels: ch0 and ch3 pressed on the same cycle -> press_pulse = 4'b1001 in a single cycle. Releasing ch3 alone -> release_pulse = 4'b1000.
- Reset mid-press: ch0 debounced high, rst for 2 cycles while still pressed -> no release_pulse, btn_state=0. After rst drops, press_pulse[0] reappears after 4 samples.
